// File: rtl/mux4_arbiter.sv
// Round-robin arbiter and select sequencer for the shared 4:1 mux, with one dead cycle between owners.
// Optional forced release after MAX_HOLD granted cycles is built when MUX4_ARB_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | no owner, arbitrate on any request
// GRANT | owner Last holds the mux until its request falls
// GAP   | dead cycle after a release, arbitrates like IDLE
module mux4_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 8
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [3:0] Req,
  output logic [3:0] Grant,
  output logic [1:0] Se1,
  output logic       Busy,
  output logic       Expired
);

  if ((MAX_HOLD < 2) || (MAX_HOLD > 255) || ((64'd1 << HOLD_W) <= 64'(MAX_HOLD))) begin : g_bad_param
    $error("mux4_arbiter: MAX_HOLD must be 2..255 and fit in HOLD_W bits");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [1:0] last, last_nxt;
  logic [3:0] grant_nxt;
  logic [1:0] se1_nxt;
  logic       busy_nxt;
  logic [1:0] pick;
  logic       req_any;

`ifdef MUX4_ARB_TIMEOUT_EN
  logic [HOLD_W-1:0] cnt, cnt_nxt;
  logic              expired_nxt;
  logic              others;
  logic              cnt_sat;

  assign others  = |(Req & ~(4'b0001 << last));
  assign cnt_sat = (cnt == HOLD_W'(MAX_HOLD - 1));
`endif

  assign req_any = |Req;

  // Lowest-priority candidate first so the nearest index after Last wins.
  always_comb begin
    pick = last;
    for (int k = 3; k >= 1; k--) begin
      if (Req[last + 2'(k)]) pick = last + 2'(k);
    end
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    grant_nxt = Grant;
    se1_nxt   = Se1;
    busy_nxt  = Busy;
`ifdef MUX4_ARB_TIMEOUT_EN
    cnt_nxt     = cnt;
    expired_nxt = 1'b0;
`endif
    case (state)
      IDLE, GAP: begin
        if (req_any) begin
          state_nxt = GRANT;
          grant_nxt = 4'b0001 << pick;
          se1_nxt   = pick;
          last_nxt  = pick;
          busy_nxt  = 1'b1;
`ifdef MUX4_ARB_TIMEOUT_EN
          cnt_nxt   = '0;
`endif
        end else begin
          state_nxt = IDLE;
          grant_nxt = 4'b0000;
          busy_nxt  = 1'b0;
        end
      end
      GRANT: begin
        if (!Req[last]) begin
          state_nxt = GAP;
          grant_nxt = 4'b0000;
          busy_nxt  = 1'b0;
        end
`ifdef MUX4_ARB_TIMEOUT_EN
        else if (cnt_sat && others) begin
          state_nxt   = GAP;
          grant_nxt   = 4'b0000;
          busy_nxt    = 1'b0;
          expired_nxt = 1'b1;
        end else if (!cnt_sat) begin
          cnt_nxt = cnt + HOLD_W'(1);
        end
`endif
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = 4'b0000;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
      last  <= 2'd3;
      Grant <= 4'b0000;
      Se1   <= 2'b00;
      Busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      Grant <= grant_nxt;
      Se1   <= se1_nxt;
      Busy  <= busy_nxt;
    end
  end

`ifdef MUX4_ARB_TIMEOUT_EN
  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt     <= '0;
      Expired <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      Expired <= expired_nxt;
    end
  end
`else
  assign Expired = 1'b0;
`endif

endmodule

// File: tb/tb_mux4_arbiter.sv
// Self-checking bench for mux4_arbiter: directed scenarios with literal expectations,
// then randomized requests/resets checked every cycle against a behavioural owner model.
module tb_mux4_arbiter;

  localparam int MAX_HOLD = 4;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic [3:0] Req = 4'b0000;
  logic [3:0] Grant;
  logic [1:0] Se1;
  logic       Busy;
  logic       Expired;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  mux4_arbiter #(.MAX_HOLD(MAX_HOLD), .HOLD_W(8)) dut (
    .Clk(Clk), .Rst(Rst), .Req(Req), .Grant(Grant),
    .Se1(Se1), .Busy(Busy), .Expired(Expired)
  );

  always #5 Clk = ~Clk;

  // Model: an owner index (-1 = nobody), most recent owner, tenure count.
  int m_owner = -1;
  int m_last  = 3;
  int m_se1   = 0;
  int m_cnt   = 0;
  bit m_exp   = 1'b0;

  function automatic int model_pick(logic [3:0] r, int last);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  always @(posedge Clk) begin
    int w;
    if (Rst) begin
      m_owner = -1; m_last = 3; m_se1 = 0; m_cnt = 0; m_exp = 1'b0;
    end else if (m_owner < 0) begin
      m_exp = 1'b0;
      w = model_pick(Req, m_last);
      if (w >= 0) begin
        m_owner = w; m_last = w; m_se1 = w; m_cnt = 0;
      end
    end else if (!Req[m_owner]) begin
      m_owner = -1; m_exp = 1'b0;
    end else begin
      m_exp = 1'b0;
`ifdef MUX4_ARB_TIMEOUT_EN
      if (m_cnt == MAX_HOLD - 1 && (Req & ~(4'b0001 << m_owner)) != 4'b0000) begin
        m_owner = -1; m_exp = 1'b1;
      end else if (m_cnt < MAX_HOLD - 1) begin
        m_cnt = m_cnt + 1;
      end
`endif
    end
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (cmp_en) begin
      chk("model_grant",   Grant, (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner));
      chk("model_se1",     {2'b00, Se1}, 4'(m_se1));
      chk("model_busy",    {3'b000, Busy}, {3'b000, (m_owner >= 0)});
      chk("model_expired", {3'b000, Expired}, {3'b000, m_exp});
    end
  end

  task automatic step(input logic [3:0] r);
    Req = r;
    @(posedge Clk);
    #2;
  endtask

  task automatic lit(input string name, input logic [3:0] g, input logic [1:0] s, input logic b);
    chk({name, "_grant"}, Grant, g);
    chk({name, "_se1"}, {2'b00, Se1}, {2'b00, s});
    chk({name, "_busy"}, {3'b000, Busy}, {3'b000, b});
  endtask

  initial begin
    Rst = 1'b1;
    step(4'b0000);
    cmp_en = 1'b1;
    step(4'b0000);
    Rst = 1'b0;
    lit("reset", 4'b0000, 2'd0, 1'b0);
    chk("reset_expired", {3'b000, Expired}, 4'b0000);

    // Full round robin with all four requesting
    step(4'b1111); lit("rr_first", 4'b0001, 2'd0, 1'b1);
    step(4'b1111); lit("rr_hold0", 4'b0001, 2'd0, 1'b1);
    step(4'b1110); lit("rr_gap0",  4'b0000, 2'd0, 1'b0);
    step(4'b1110); lit("rr_own1",  4'b0010, 2'd1, 1'b1);
    step(4'b1100); lit("rr_gap1",  4'b0000, 2'd1, 1'b0);
    step(4'b1100); lit("rr_own2",  4'b0100, 2'd2, 1'b1);
    step(4'b1000); lit("rr_gap2",  4'b0000, 2'd2, 1'b0);
    step(4'b1000); lit("rr_own3",  4'b1000, 2'd3, 1'b1);
    step(4'b0000); step(4'b0000);

    // Last=0, then 1001 goes to 3, then wrap to 0
    step(4'b0001); lit("wrap_setup", 4'b0001, 2'd0, 1'b1);
    step(4'b0000);
    step(4'b1001); lit("skip_last", 4'b1000, 2'd3, 1'b1);
    step(4'b0001); lit("wrap_gap",  4'b0000, 2'd3, 1'b0);
    step(4'b0001); lit("wrap_to0",  4'b0001, 2'd0, 1'b1);
    step(4'b0000);

    // Owner drop and new request on the same edge
    step(4'b0100); lit("sim_own2", 4'b0100, 2'd2, 1'b1);
    step(4'b0010); lit("sim_gap",  4'b0000, 2'd2, 1'b0);
    step(4'b0010); lit("sim_own1", 4'b0010, 2'd1, 1'b1);
    step(4'b0000);

    // Reset while granted
    step(4'b1111); lit("rst_pre", 4'b0100, 2'd2, 1'b1);
    Rst = 1'b1;
    step(4'b1111); lit("rst_mid", 4'b0000, 2'd0, 1'b0);
    Rst = 1'b0;
    step(4'b1111); lit("rst_after", 4'b0001, 2'd0, 1'b1);
    step(4'b0000); step(4'b0000);

    // Tenure limit with two requesters
    Rst = 1'b1; step(4'b0000); Rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(4'b0011); lit("hold_two", 4'b0001, 2'd0, 1'b1);
    end
    step(4'b0011);
`ifdef MUX4_ARB_TIMEOUT_EN
    lit("timeout_gap", 4'b0000, 2'd0, 1'b0);
    chk("timeout_expired", {3'b000, Expired}, 4'b0001);
    step(4'b0011); lit("timeout_next", 4'b0010, 2'd1, 1'b1);
    chk("timeout_pulse_end", {3'b000, Expired}, 4'b0000);
`else
    lit("notimeout_hold", 4'b0001, 2'd0, 1'b1);
    chk("notimeout_expired", {3'b000, Expired}, 4'b0000);
`endif
    // Single requester keeps the grant indefinitely
    for (int i = 0; i < 25; i++) begin
      step(4'b0001);
      chk("solo_expired", {3'b000, Expired}, 4'b0000);
    end
    lit("solo_hold", 4'b0001, 2'd0, 1'b1);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 4000; i++) begin
      Rst = ($urandom_range(0, 249) == 0);
      if ($urandom_range(0, 3) == 0) step(4'($urandom_range(0, 15)));
      else step(Req);
    end
    Rst = 1'b0;
    step(4'b0000);
    @(negedge Clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
